// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between two requesters with packet-locked
//   round-robin arbitration. A granted requester keeps the transmitter until
//   it presents a byte flagged last, or until it leaves valid low for TIMEOUT
//   cycles while the arbiter is waiting for its next byte.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-low reset
//   req_valid_i  per-requester byte valid
//   req_data_i   requester n byte at [n*DATA_W +: DATA_W]
//   req_last_i   per-requester last-byte-of-packet flag
//   req_ready_o  per-requester accept (handshake = valid & ready)
//   tx_data_o    byte presented to the transmitter, held until next handshake
//   tx_start_o   one-cycle start pulse to the transmitter
//   tx_busy_i    transmitter busy, high from the cycle after tx_start_o
//   grant_o      index of the current / most recent owner
//   lock_o       high while a packet owns the transmitter
//   timeout_o    one-cycle pulse when a stalled owner is forcibly released
module uart_tx_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          req_valid_i,
  input  logic [2*DATA_W-1:0] req_data_i,
  input  logic [1:0]          req_last_i,
  output logic [1:0]          req_ready_o,
  output logic [DATA_W-1:0]   tx_data_o,
  output logic                tx_start_o,
  input  logic                tx_busy_i,
  output logic                grant_o,
  output logic                lock_o,
  output logic                timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] START = 2'd2;
  localparam logic [1:0] BUSY  = 2'd3;

  logic [1:0]        state_r;
  logic              grant_r;
  logic              lock_r;
  logic              ptr_r;
  logic              last_r;
  logic              tx_start_r;
  logic              timeout_r;
  logic [DATA_W-1:0] tx_data_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [1:0]        ready_s;
  logic              pick_s;
  logic              owner_valid_s;
  logic              owner_last_s;
  logic [DATA_W-1:0] owner_data_s;
  logic              hs_s;

  assign owner_valid_s = req_valid_i[grant_r];
  assign owner_last_s  = req_last_i[grant_r];
  assign owner_data_s  = req_data_i[grant_r*DATA_W +: DATA_W];
  assign hs_s          = owner_valid_s && ready_s[grant_r];

  // Ready only for the owner while waiting for a byte and the transmitter is free.
  always_comb begin
    ready_s = 2'b00;
    if ((state_r == LOAD) && !tx_busy_i) begin
      ready_s[grant_r] = 1'b1;
    end else begin
      ready_s = 2'b00;
    end
  end

  // Requester selection in IDLE: a lone request wins, a tie goes to the pointer.
  always_comb begin
    pick_s = 1'b0;
    if (req_valid_i == 2'b11) begin
      pick_s = ptr_r;
    end else if (req_valid_i[1]) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Arbitration FSM, byte capture, stall timer and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= IDLE;
      grant_r    <= 1'b0;
      lock_r     <= 1'b0;
      ptr_r      <= 1'b0;
      last_r     <= 1'b0;
      tx_start_r <= 1'b0;
      timeout_r  <= 1'b0;
      tx_data_r  <= {DATA_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      tx_start_r <= 1'b0;
      timeout_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|req_valid_i) begin
            grant_r <= pick_s;
            lock_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= LOAD;
          end
        end
        LOAD: begin
          if (hs_s) begin
            tx_data_r  <= owner_data_s;
            last_r     <= owner_last_s;
            tx_start_r <= 1'b1;
            cnt_r      <= {CNT_W{1'b0}};
            state_r    <= START;
          end else if (!owner_valid_s) begin
            // Owner idle mid-packet: release once the stall reaches TIMEOUT cycles.
            if (cnt_r == CNT_LAST) begin
              timeout_r <= 1'b1;
              lock_r    <= 1'b0;
              ptr_r     <= ~grant_r;
              cnt_r     <= {CNT_W{1'b0}};
              state_r   <= IDLE;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        START: begin
          state_r <= BUSY;
        end
        BUSY: begin
          if (!tx_busy_i) begin
            if (last_r) begin
              lock_r  <= 1'b0;
              ptr_r   <= ~grant_r;
              state_r <= IDLE;
            end else begin
              state_r <= LOAD;
            end
          end
        end
        default: begin
          lock_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = ready_s;
  assign tx_data_o   = tx_data_r;
  assign tx_start_o  = tx_start_r;
  assign grant_o     = grant_r;
  assign lock_o      = lock_r;
  assign timeout_o   = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter. Two requester drivers play bytes from
//   per-requester queues; a transmitter model stays busy for a fixed time after
//   each start. Expected (owner, byte) pairs are queued as stimulus is written
//   and compared against each start pulse.
module tb_uart_tx_arbiter;

  localparam int DATA_W   = 8;
  localparam int TIMEOUT  = 16;
  localparam int BUSY_LEN = 20;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [1:0]        req_valid_i;
  logic [15:0]       req_data_i;
  logic [1:0]        req_last_i;
  logic [1:0]        req_ready_o;
  logic [7:0]        tx_data_o;
  logic              tx_start_o;
  logic              tx_busy;
  logic              grant_o;
  logic              lock_o;
  logic              timeout_o;

  logic              v0, v1, l0, l1;
  logic [7:0]        d0, d1;
  logic [8:0]        q0[$];
  logic [8:0]        q1[$];
  logic [8:0]        exp_q[$];
  int                busy_cnt = 0;
  int                total = 0;
  int                bad = 0;
  int                starts = 0;
  int                pushed = 0;
  int                to_cnt = 0;

  assign req_valid_i = {v1, v0};
  assign req_data_i  = {d1, d0};
  assign req_last_i  = {l1, l0};
  assign tx_busy     = (busy_cnt != 0);

  uart_tx_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_start_o  (tx_start_o),
    .tx_busy_i   (tx_busy),
    .grant_o     (grant_o),
    .lock_o      (lock_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for BUSY_LEN cycles after each start, own reset.
  always @(posedge clk) begin
    if (tx_start_o) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester 0 driver.
  initial begin
    bit h;
    logic [8:0] tmp;
    v0 = 1'b0; d0 = 8'h00; l0 = 1'b0;
    forever begin
      @(negedge clk);
      h = v0 && req_ready_o[0] && rst_i;
      @(posedge clk);
      #1;
      if (h && q0.size() > 0) tmp = q0.pop_front();
      if (q0.size() > 0) begin v0 = 1'b1; {l0, d0} = q0[0]; end
      else v0 = 1'b0;
    end
  end

  // Requester 1 driver.
  initial begin
    bit h;
    logic [8:0] tmp;
    v1 = 1'b0; d1 = 8'h00; l1 = 1'b0;
    forever begin
      @(negedge clk);
      h = v1 && req_ready_o[1] && rst_i;
      @(posedge clk);
      #1;
      if (h && q1.size() > 0) tmp = q1.pop_front();
      if (q1.size() > 0) begin v1 = 1'b1; {l1, d1} = q1[0]; end
      else v1 = 1'b0;
    end
  end

  // Output monitor: scoreboard pops on each start, plus protocol checks.
  initial begin
    bit prev_hs;
    bit prev_start;
    logic [8:0] e;
    prev_hs = 1'b0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        prev_hs = 1'b0;
        prev_start = 1'b0;
      end else begin
        check("other_ready", {31'd0, req_ready_o[~grant_o]}, 32'd0);
        if (tx_start_o) begin
          starts++;
          if (exp_q.size() == 0) begin
            check("unexpected_start", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", {24'd0, tx_data_o}, {24'd0, e[7:0]});
            check("start_grant", {31'd0, grant_o}, {31'd0, e[8]});
          end
          check("start_while_busy", {31'd0, tx_busy}, 32'd0);
          check("start_after_hs", {31'd0, prev_hs}, 32'd1);
          check("start_pulse", {31'd0, prev_start}, 32'd0);
        end
        if (timeout_o) begin
          to_cnt++;
          check("timeout_lock", {31'd0, lock_o}, 32'd0);
        end
        prev_start = tx_start_o;
        prev_hs = (v0 && req_ready_o[0]) || (v1 && req_ready_o[1]);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  {24'd0, tx_data_o}, 32'd0);
    check({tag, "_start"}, {31'd0, tx_start_o}, 32'd0);
    check({tag, "_ready"}, {30'd0, req_ready_o}, 32'd0);
    check({tag, "_grant"}, {31'd0, grant_o}, 32'd0);
    check({tag, "_lock"},  {31'd0, lock_o}, 32'd0);
    check({tag, "_to"},    {31'd0, timeout_o}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_i = 1'b0;
    #1 check_reset_outputs(tag);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic push0(input logic [7:0] d, input logic last);
    q0.push_back({last, d});
  endtask

  task automatic push1(input logic [7:0] d, input logic last);
    q1.push_back({last, d});
  endtask

  task automatic expect_tx(input logic g, input logic [7:0] d);
    exp_q.push_back({g, d});
    pushed++;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 &&
          !lock_o && !tx_busy && !v0 && !v1) done = 1'b1;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!tx_busy && n < 200) begin @(negedge clk); n++; end
    check(tag, {31'd0, tx_busy}, 32'd1);
  endtask

  initial begin
    bit seen;
    rst_i = 1'b0;
    #7 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_i = 1'b1;

    // T1: single-byte packet from req0.
    push0(8'hAA, 1'b1); expect_tx(1'b0, 8'hAA);
    wait_busy("t1_busy");
    check("t1_lock_busy", {31'd0, lock_o}, 32'd1);
    check("t1_grant_busy", {31'd0, grant_o}, 32'd0);
    wait_idle("t1_idle");
    check("t1_grant_end", {31'd0, grant_o}, 32'd0);

    // T2: simultaneous requests right after reset, req0 preferred.
    do_reset("rst2");
    push0(8'h11, 1'b1); push1(8'h22, 1'b1);
    expect_tx(1'b0, 8'h11); expect_tx(1'b1, 8'h22);
    wait_idle("t2_idle");
    check("t2_grant_end", {31'd0, grant_o}, 32'd1);

    // T3: req1 multi-byte packet locks out a waiting req0.
    push1(8'h55, 1'b0); push1(8'h0F, 1'b0); push1(8'hF0, 1'b1);
    expect_tx(1'b1, 8'h55); expect_tx(1'b1, 8'h0F); expect_tx(1'b1, 8'hF0);
    repeat (3) @(negedge clk);
    push0(8'h99, 1'b1); expect_tx(1'b0, 8'h99);
    for (int i = 0; i < 6; i++) begin
      repeat (10) @(negedge clk);
      check("t3_ready0", {31'd0, req_ready_o[0]}, 32'd0);
      check("t3_lock", {31'd0, lock_o}, 32'd1);
      check("t3_grant", {31'd0, grant_o}, 32'd1);
    end
    wait_idle("t3_idle");

    // T4: req0 stalls mid-packet, timeout hands over to req1.
    push0(8'h33, 1'b0); expect_tx(1'b0, 8'h33);
    repeat (3) @(negedge clk);
    push1(8'h44, 1'b1); expect_tx(1'b1, 8'h44);
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (timeout_o) seen = 1'b1;
    end
    check("t4_timeout_seen", {31'd0, seen}, 32'd1);
    check("t4_to_lock", {31'd0, lock_o}, 32'd0);
    check("t4_to_grant", {31'd0, grant_o}, 32'd0);
    @(negedge clk);
    check("t4_to_pulse", {31'd0, timeout_o}, 32'd0);
    wait_idle("t4_idle");
    check("t4_to_count", to_cnt, 32'd1);

    // T5: reset during BUSY while the pointer favours req1.
    push0(8'h5A, 1'b1); expect_tx(1'b0, 8'h5A);
    wait_idle("t5a_idle");
    push1(8'h66, 1'b1); expect_tx(1'b1, 8'h66);
    wait_busy("t5_busy");
    repeat (3) @(negedge clk);
    check("t5_lock_pre", {31'd0, lock_o}, 32'd1);
    do_reset("rst5");
    push0(8'h77, 1'b1); push1(8'h88, 1'b1);
    expect_tx(1'b0, 8'h77); expect_tx(1'b1, 8'h88);
    wait_idle("t5_idle");

    // T6: both stream single-byte packets; grants alternate.
    for (int i = 0; i < 4; i++) begin
      push0(8'hA0 + 8'(i), 1'b1);
      push1(8'hB0 + 8'(i), 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      expect_tx(1'b0, 8'hA0 + 8'(i));
      expect_tx(1'b1, 8'hB0 + 8'(i));
    end
    wait_idle("t6_idle");

    check("start_count", starts, pushed);
    check("exp_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between two requesters (e.g. debug console and CPU mailbox) using packet-locked round-robin arbitration. Each requester presents bytes with a valid/ready handshake and a last flag. The arbiter forwards one byte at a time to the transmitter's start/busy interface and holds the grant until the packet ends or the owner stalls past a timeout. It sits between the requesters and the uart transmitter, alongside the uart receiver.

Parameters:
DATA_W, 8, byte width forwarded to the transmitter
TIMEOUT, 1024, cycles a locked owner may leave valid low before the grant is forcibly released (>=2)

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous, active-low reset
req_valid_i  input  2  per-requester byte valid
req_data_i  input  2*DATA_W  requester n data at bits [n*DATA_W +: DATA_W]
req_last_i  input  2  per-requester last-byte-of-packet flag
req_ready_o  output  2  per-requester byte accepted (handshake = valid & ready)
tx_data_o  output  DATA_W  byte to transmitter
tx_start_o  output  1  one-cycle start pulse to transmitter
tx_busy_i  input  1  transmitter busy; high from the cycle after tx_start_o until the stop bit completes
grant_o  output  1  index of current/last owner
lock_o  output  1  high while a packet owns the transmitter
timeout_o  output  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst_i low, async): state IDLE; tx_data_o=0, tx_start_o=0, req_ready_o=0, grant_o=0, lock_o=0, timeout_o=0; rr pointer=0 (req0 preferred); timeout counter=0. Takes effect immediately. In-flight transmitter frame is not aborted (transmitter has its own reset).
- States: IDLE, LOAD, START, BUSY.
- IDLE: lock_o=0, req_ready_o=0. If any req_valid_i is high, grant_o <= chosen index and lock_o <= 1, then go to LOAD. Only one valid: that one wins. Both valid: pointer wins.
- LOAD: req_ready_o[grant_o] = !tx_busy_i (combinational from registered state); the other ready bit is 0.
  - On handshake: tx_data_o <= data, store last flag, tx_start_o <= 1, counter <= 0, go to START.
  - No valid from owner: counter increments. At counter==TIMEOUT-1: timeout_o pulses, lock_o <= 0, pointer <= ~grant_o, go to IDLE.
- START: tx_start_o high this cycle only; go to BUSY.
- BUSY: wait for tx_busy_i==0.
  - If stored last==1: lock_o <= 0, pointer <= ~grant_o, go to IDLE.
  - Otherwise: go to LOAD, keeping the grant.
- Latency: handshake at cycle N gives tx_start_o and the new tx_data_o at N+1. tx_data_o holds until the next handshake.
- Non-owner valid is ignored while lock_o=1; its ready stays 0. Requesters must hold data/last stable while valid and not ready.
- A new owner's first byte is accepted no earlier than 2 cycles after the previous release: one cycle to return to IDLE, then one cycle in IDLE.
- Owner dropping valid mid-packet is legal; only TIMEOUT expiry releases the grant.
- last asserted on the first byte gives a single-byte packet.
- Pointer flips only on release (last or timeout), never per byte.
- tx_busy_i high in IDLE or LOAD (external use) blocks ready; no start is issued while busy.

Test Plan:
- Reset, req0 sends 0xAA with last=1, transmitter model busy 20 cycles: tx_start_o one pulse at handshake+1 with tx_data_o=0xAA; lock_o falls after busy drops; grant_o=0.
- Both valid in the same cycle after reset (req0 0x11 last, req1 0x22 last): 0x11 transmitted first, then 0x22; grant_o 0→1; pointer returns to 0.
- req1 sends 3-byte packet 0x55,0x0F,0xF0 (last on 3rd) while req0 holds valid with 0x99: req0 ready stays 0; bytes go out in order; 0x99 is sent only after release.
- req0 sends a byte without last, then drops valid: after TIMEOUT=16 cycles in LOAD, timeout_o pulses once, lock_o=0; waiting req1 is then granted.
- Assert rst_i low during BUSY of a packet: all outputs return to reset values immediately; after deassertion, arbitration restarts with req0 preferred.
- Both requesters continuously stream single-byte packets: grants strictly alternate 0,1,0,1; exactly one tx_start_o per busy period.
